// File: rtl/core_pkg.sv
// Shared core definitions: hazard FSM state encoding and the MUL/DIV
// occupancy defaults that the mul/div unit also uses.
package core_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } hz_state_t;

  localparam int MUL_CYCLES_DEF = 4;
  localparam int DIV_CYCLES_DEF = 33;

endpackage

// File: rtl/hazard_unit.sv
// Pipeline hazard/stall controller: load-use, multicycle MUL/DIV, memory wait
// and taken-branch handling, plus a saturating stall-cycle counter.
//
// state   | meaning
// IDLE    | no multicycle op in flight; a MUL/DIV entering EX stalls this cycle
// MD_BUSY | MUL/DIV occupying EX; cnt counts down to its final cycle
module hazard_unit
  import core_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CNT_W      = 6,
  parameter int STALL_W    = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1Addr_id,
  input  logic [4:0]  rs2Addr_id,
  input  logic        rs1Used_id,
  input  logic        rs2Used_id,
  input  logic        MemRead_ex,
  input  logic [4:0]  rdAddr_ex,
  input  logic        MulDivStart_ex,
  input  logic        MulDivIsDiv_ex,
  input  logic        BranchTaken_ex,
  input  logic        MemAccess_mem,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IDEXWrite,
  output logic        EXMEMWrite,
  output logic        MEMWBWrite,
  output logic        IFIDFlush,
  output logic        IDEXFlush,
  output logic        EXMEMFlush,
  output logic        MEMWBFlush,
  output logic        MulDivDone,
  output logic        Busy,
  output logic [31:0] StallCount
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 2);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);

  hz_state_t          state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [STALL_W-1:0] stall_cnt_q;
  logic [STALL_W-1:0] stall_cnt_d;

  logic memwait;
  logic md_stall;
  logic load_use;
  logic cnt_zero;

  function automatic logic load_use_hit(
    input logic       mem_read,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic       rs1_used,
    input logic [4:0] rs2,
    input logic       rs2_used
  );
    return mem_read && (rd != 5'd0) &&
           ((rs1_used && (rs1 == rd)) || (rs2_used && (rs2 == rd)));
  endfunction

  assign cnt_zero = (cnt_q == '0);
  assign memwait  = MemAccess_mem && !MemReady;
  assign md_stall = ((state_q == IDLE) && MulDivStart_ex) ||
                    ((state_q == MD_BUSY) && !cnt_zero);
  assign load_use = load_use_hit(MemRead_ex, rdAddr_ex, rs1Addr_id, rs1Used_id,
                                 rs2Addr_id, rs2Used_id);

  // Branch sits above load-use: the dependent ID instruction is wrong-path.
  always_comb begin
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    IDEXWrite  = 1'b1;
    EXMEMWrite = 1'b1;
    MEMWBWrite = 1'b1;
    IFIDFlush  = 1'b0;
    IDEXFlush  = 1'b0;
    EXMEMFlush = 1'b0;
    MEMWBFlush = 1'b0;
    if (memwait) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXWrite  = 1'b0;
      EXMEMWrite = 1'b0;
      MEMWBWrite = 1'b0;
      MEMWBFlush = 1'b1;
    end else if (md_stall) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXWrite  = 1'b0;
      EXMEMFlush = 1'b1;
    end else if (BranchTaken_ex) begin
      IFIDFlush  = 1'b1;
      IDEXFlush  = 1'b1;
    end else if (load_use) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEXFlush  = 1'b1;
    end
  end

  assign MulDivDone = (state_q == MD_BUSY) && cnt_zero && !memwait;
  assign Busy       = (state_q == MD_BUSY);

  // The countdown keeps running under memwait; only the final release waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (MulDivStart_ex && !memwait) begin
            state_q <= MD_BUSY;
            cnt_q   <= MulDivIsDiv_ex ? DIV_LOAD : MUL_LOAD;
          end
        end
        MD_BUSY: begin
          if (!cnt_zero) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else if (!memwait) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!PCWrite && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign StallCount = 32'(stall_cnt_q);

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit; a second narrow-counter instance
// exercises stall-count saturation without needing billions of cycles.
module tb_hazard_unit;
  import core_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1Addr_id, rs2Addr_id, rdAddr_ex;
  logic        rs1Used_id, rs2Used_id, MemRead_ex;
  logic        MulDivStart_ex, MulDivIsDiv_ex, BranchTaken_ex;
  logic        MemAccess_mem, MemReady;

  logic        PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, MEMWBWrite;
  logic        IFIDFlush, IDEXFlush, EXMEMFlush, MEMWBFlush;
  logic        MulDivDone, Busy;
  logic [31:0] StallCount;

  logic        s_PCWrite, s_IFIDWrite, s_IDEXWrite, s_EXMEMWrite, s_MEMWBWrite;
  logic        s_IFIDFlush, s_IDEXFlush, s_EXMEMFlush, s_MEMWBFlush;
  logic        s_MulDivDone, s_Busy;
  logic [31:0] s_StallCount;

  int checks   = 0;
  int failures = 0;
  int exp_sc   = 0;

  logic [4:0] wr;
  logic [3:0] fl;
  assign wr = {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, MEMWBWrite};
  assign fl = {IFIDFlush, IDEXFlush, EXMEMFlush, MEMWBFlush};

  hazard_unit dut (
    .clk(clk), .rst_n(rst_n),
    .rs1Addr_id(rs1Addr_id), .rs2Addr_id(rs2Addr_id),
    .rs1Used_id(rs1Used_id), .rs2Used_id(rs2Used_id),
    .MemRead_ex(MemRead_ex), .rdAddr_ex(rdAddr_ex),
    .MulDivStart_ex(MulDivStart_ex), .MulDivIsDiv_ex(MulDivIsDiv_ex),
    .BranchTaken_ex(BranchTaken_ex),
    .MemAccess_mem(MemAccess_mem), .MemReady(MemReady),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXWrite(IDEXWrite),
    .EXMEMWrite(EXMEMWrite), .MEMWBWrite(MEMWBWrite),
    .IFIDFlush(IFIDFlush), .IDEXFlush(IDEXFlush),
    .EXMEMFlush(EXMEMFlush), .MEMWBFlush(MEMWBFlush),
    .MulDivDone(MulDivDone), .Busy(Busy), .StallCount(StallCount)
  );

  hazard_unit #(.STALL_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .rs1Addr_id(rs1Addr_id), .rs2Addr_id(rs2Addr_id),
    .rs1Used_id(rs1Used_id), .rs2Used_id(rs2Used_id),
    .MemRead_ex(MemRead_ex), .rdAddr_ex(rdAddr_ex),
    .MulDivStart_ex(MulDivStart_ex), .MulDivIsDiv_ex(MulDivIsDiv_ex),
    .BranchTaken_ex(BranchTaken_ex),
    .MemAccess_mem(MemAccess_mem), .MemReady(MemReady),
    .PCWrite(s_PCWrite), .IFIDWrite(s_IFIDWrite), .IDEXWrite(s_IDEXWrite),
    .EXMEMWrite(s_EXMEMWrite), .MEMWBWrite(s_MEMWBWrite),
    .IFIDFlush(s_IFIDFlush), .IDEXFlush(s_IDEXFlush),
    .EXMEMFlush(s_EXMEMFlush), .MEMWBFlush(s_MEMWBFlush),
    .MulDivDone(s_MulDivDone), .Busy(s_Busy), .StallCount(s_StallCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr_inputs();
    rs1Addr_id = '0; rs2Addr_id = '0; rdAddr_ex = '0;
    rs1Used_id = 1'b0; rs2Used_id = 1'b0; MemRead_ex = 1'b0;
    MulDivStart_ex = 1'b0; MulDivIsDiv_ex = 1'b0; BranchTaken_ex = 1'b0;
    MemAccess_mem = 1'b0; MemReady = 1'b1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    clr_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    settle();
    chk("rst_wr", 32'(wr), 32'h1F);
    chk("rst_fl", 32'(fl), 32'h0);
    chk("rst_busy", 32'(Busy), 32'h0);
    chk("rst_done", 32'(MulDivDone), 32'h0);
    chk("rst_sc", StallCount, 32'h0);
    adv();

    // load-use on rs1
    MemRead_ex = 1'b1; rdAddr_ex = 5'd5; rs1Addr_id = 5'd5; rs1Used_id = 1'b1;
    settle();
    chk("lu_rs1_wr", 32'(wr), 32'h07);
    chk("lu_rs1_fl", 32'(fl), 32'h4);
    exp_sc++;
    adv();
    clr_inputs();
    settle();
    chk("lu_bubble_wr", 32'(wr), 32'h1F);
    chk("lu_bubble_fl", 32'(fl), 32'h0);
    chk("lu_sc", StallCount, 32'(exp_sc));
    adv();

    MemRead_ex = 1'b1; rdAddr_ex = 5'd0; rs1Addr_id = 5'd0; rs1Used_id = 1'b1;
    settle();
    chk("lu_x0_wr", 32'(wr), 32'h1F);
    chk("lu_x0_fl", 32'(fl), 32'h0);
    adv();

    clr_inputs();
    MemRead_ex = 1'b1; rdAddr_ex = 5'd7; rs1Addr_id = 5'd3; rs1Used_id = 1'b1;
    rs2Addr_id = 5'd7; rs2Used_id = 1'b1;
    settle();
    chk("lu_rs2_wr", 32'(wr), 32'h07);
    exp_sc++;
    adv();

    rs2Used_id = 1'b0;
    settle();
    chk("lu_rs2_unused_wr", 32'(wr), 32'h1F);
    adv();

    clr_inputs();
    MemRead_ex = 1'b0; rdAddr_ex = 5'd9; rs1Addr_id = 5'd9; rs1Used_id = 1'b1;
    settle();
    chk("lu_noload_wr", 32'(wr), 32'h1F);
    adv();

    // branch together with load-use
    clr_inputs();
    MemRead_ex = 1'b1; rdAddr_ex = 5'd5; rs1Addr_id = 5'd5; rs1Used_id = 1'b1;
    BranchTaken_ex = 1'b1;
    settle();
    chk("br_lu_wr", 32'(wr), 32'h1F);
    chk("br_lu_fl", 32'(fl), 32'hC);
    adv();

    // multiply: stall t..t+2, done t+3
    clr_inputs();
    for (int k = 0; k < 4; k++) begin
      MulDivStart_ex = 1'b1; MulDivIsDiv_ex = 1'b0;
      settle();
      chk($sformatf("mul_done_%0d", k), 32'(MulDivDone), (k == 3) ? 32'h1 : 32'h0);
      chk($sformatf("mul_busy_%0d", k), 32'(Busy), (k >= 1) ? 32'h1 : 32'h0);
      chk($sformatf("mul_wr_%0d", k), 32'(wr), (k == 3) ? 32'h1F : 32'h03);
      chk($sformatf("mul_fl_%0d", k), 32'(fl), (k == 3) ? 32'h0 : 32'h2);
      if (k < 3) exp_sc++;
      adv();
    end
    clr_inputs();
    settle();
    chk("mul_after_busy", 32'(Busy), 32'h0);
    chk("mul_sc", StallCount, 32'(exp_sc));
    chk("mul_sat_sc", s_StallCount, 32'(exp_sc));
    adv();

    // divide with memwait at k=32,33 (cnt already 0): done moves to k=34
    for (int k = 0; k < 35; k++) begin
      MulDivStart_ex = 1'b1; MulDivIsDiv_ex = 1'b1;
      MemAccess_mem = 1'b1; MemReady = !(k == 32 || k == 33);
      settle();
      chk($sformatf("div_done_%0d", k), 32'(MulDivDone), (k == 34) ? 32'h1 : 32'h0);
      chk($sformatf("div_pcw_%0d", k), 32'(PCWrite), (k == 34) ? 32'h1 : 32'h0);
      if (k == 32) begin
        chk("div_mw_wr", 32'(wr), 32'h00);
        chk("div_mw_fl", 32'(fl), 32'h1);
        chk("div_mw_busy", 32'(Busy), 32'h1);
      end
      if (k < 34) exp_sc++;
      adv();
    end
    clr_inputs();
    settle();
    chk("div_after_busy", 32'(Busy), 32'h0);
    chk("div_after_done", 32'(MulDivDone), 32'h0);
    chk("div_sc", StallCount, 32'(exp_sc));
    chk("div_sat_sc", s_StallCount, 32'hF);
    adv();

    // reset in the middle of a divide (cnt=10 after 22 edges)
    for (int k = 0; k < 22; k++) begin
      MulDivStart_ex = 1'b1; MulDivIsDiv_ex = 1'b1;
      settle();
      adv();
    end
    exp_sc += 22;
    settle();
    chk("rdiv_busy_pre", 32'(Busy), 32'h1);
    chk("rdiv_sc_pre", StallCount, 32'(exp_sc));
    #2;
    rst_n = 1'b0;
    clr_inputs();
    #1;
    chk("rdiv_busy", 32'(Busy), 32'h0);
    chk("rdiv_wr", 32'(wr), 32'h1F);
    chk("rdiv_sc", StallCount, 32'h0);
    chk("rdiv_sat_sc", s_StallCount, 32'h0);
    adv();
    rst_n = 1'b1;
    settle();
    chk("rdiv_post_busy", 32'(Busy), 32'h0);
    adv();

    // 20 memwait stalls: wide counter 20, narrow one pinned at max
    for (int k = 0; k < 20; k++) begin
      MemAccess_mem = 1'b1; MemReady = 1'b0;
      settle();
      adv();
    end
    clr_inputs();
    settle();
    chk("sat_sc_wide", StallCount, 32'd20);
    chk("sat_sc_narrow", s_StallCount, 32'hF);
    adv();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
